// File: rtl/switch_debounce_ctrl_if.sv
// Bundles the switch-side signals of the debounce controller: raw inputs and run
// enable in, clean levels plus edge pulses and per-channel busy flags out.
interface switch_debounce_ctrl_if #(
  parameter int N = 4
);
  logic         EN;
  logic [N-1:0] SW;
  logic [N-1:0] STATE;
  logic [N-1:0] RISE;
  logic [N-1:0] FALL;
  logic [N-1:0] BUSY;

  modport master (
    output EN, SW,
    input  STATE, RISE, FALL, BUSY
  );

  modport slave (
    input  EN, SW,
    output STATE, RISE, FALL, BUSY
  );
endinterface

// File: rtl/switch_debounce_ctrl.sv
// Multi-channel switch debouncer: synchronise raw inputs, sample them on a shared
// prescaler tick, and accept a level only after STABLE_CNT agreeing samples.
module switch_debounce_ctrl #(
  parameter int N          = 4,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  switch_debounce_ctrl_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] LASTDIV = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LASTCNT = CW'(STABLE_CNT - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } chan_state_t;

  logic [N-1:0]  s1;
  logic [N-1:0]  ss;
  logic [PW-1:0] presc;
  logic          tick;
  chan_state_t   fsm [N];
  logic [CW-1:0] cnt [N];
  logic [N-1:0]  state;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [N-1:0]  busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '0;
      ss <= '0;
    end else begin
      s1 <= bus.SW;
      ss <= s1;
    end
  end

  // The prescaler keeps its count while disabled, so a frozen channel resumes mid-interval.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
    end else if (bus.EN) begin
      if (presc == LASTDIV) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign tick = bus.EN && (presc == LASTDIV);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        fsm[i] <= STABLE;
        cnt[i] <= '0;
      end
      state <= '0;
      rise  <= '0;
      fall  <= '0;
      busy  <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < N; i++) begin
        if (tick) begin
          case (fsm[i])
            STABLE: begin
              if (ss[i] != state[i]) begin
                if (STABLE_CNT == 1) begin
                  state[i] <= ss[i];
                  rise[i]  <= ss[i];
                  fall[i]  <= ~ss[i];
                end else begin
                  fsm[i]  <= PENDING;
                  cnt[i]  <= CW'(1);
                  busy[i] <= 1'b1;
                end
              end
            end
            PENDING: begin
              // A sample that agrees with the current level means the change was a glitch.
              if (ss[i] == state[i]) begin
                fsm[i]  <= STABLE;
                cnt[i]  <= '0;
                busy[i] <= 1'b0;
              end else if (cnt[i] == LASTCNT) begin
                state[i] <= ss[i];
                rise[i]  <= ss[i];
                fall[i]  <= ~ss[i];
                fsm[i]   <= STABLE;
                cnt[i]   <= '0;
                busy[i]  <= 1'b0;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
            default: begin
              fsm[i]  <= STABLE;
              cnt[i]  <= '0;
              busy[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.STATE = state;
  assign bus.RISE  = rise;
  assign bus.FALL  = fall;
  assign bus.BUSY  = busy;

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl (N=4, TICK_DIV=4, STABLE_CNT=3); expected
// edge pulses are queued with their cycle number and checked by a separate monitor.
module tb_switch_debounce_ctrl;

  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int         at;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] state;
  } pulse_t;

  pulse_t q[$];
  pulse_t mon;

  switch_debounce_ctrl_if #(.N(4)) bus ();

  switch_debounce_ctrl #(
    .N(4),
    .TICK_DIV(4),
    .STABLE_CNT(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Cycle index: 0 after the last reset edge, k after the k-th edge that follows it.
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goTo(input int k);
    while (cyc < k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input int k, input logic [3:0] sw);
    goTo(k);
    bus.SW = sw;
  endtask

  always @(negedge CLK) begin
    if ((bus.RISE | bus.FALL) != 4'b0) begin
      if (q.size() == 0) begin
        checkOutput("unexpected pulse", {28'b0, bus.RISE | bus.FALL}, 32'h0);
      end else begin
        mon = q.pop_front();
        checkOutput("pulse cycle", cyc, mon.at);
        checkOutput("pulse rise",  {28'b0, bus.RISE},  {28'b0, mon.rise});
        checkOutput("pulse fall",  {28'b0, bus.FALL},  {28'b0, mon.fall});
        checkOutput("pulse state", {28'b0, bus.STATE}, {28'b0, mon.state});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST    = 1'b1;
    bus.EN = 1'b1;
    bus.SW = 4'hF;
    @(posedge CLK);
    #1;
    checkOutput("in reset state", {28'b0, bus.STATE}, 32'h0);
    checkOutput("in reset busy",  {28'b0, bus.BUSY},  32'h0);
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    bus.SW = 4'h0;

    goTo(1);
    checkOutput("after reset state", {28'b0, bus.STATE}, 32'h0);
    checkOutput("after reset rise",  {28'b0, bus.RISE},  32'h0);
    checkOutput("after reset fall",  {28'b0, bus.FALL},  32'h0);
    checkOutput("after reset busy",  {28'b0, bus.BUSY},  32'h0);

    // Clean press on channel 0: seen at tick 4, accepted at tick 12.
    applyStimulus(1, 4'b0001);
    q.push_back('{at: 12, rise: 4'b0001, fall: 4'b0000, state: 4'b0001});
    goTo(3);
    checkOutput("press busy before tick", {28'b0, bus.BUSY}, 32'h0);
    goTo(4);
    checkOutput("press busy at tick", {28'b0, bus.BUSY}, 32'h1);
    goTo(13);
    checkOutput("press state", {28'b0, bus.STATE}, 32'h1);
    checkOutput("press rise cleared", {28'b0, bus.RISE}, 32'h0);
    checkOutput("press busy done", {28'b0, bus.BUSY}, 32'h0);

    // Bounce on channel 1: two disagreeing samples, then rejected at tick 24.
    applyStimulus(13, 4'b0011);
    goTo(16);
    checkOutput("bounce busy set", {28'b0, bus.BUSY}, 32'h2);
    applyStimulus(18, 4'b0001);
    goTo(20);
    checkOutput("bounce busy held", {28'b0, bus.BUSY}, 32'h2);
    goTo(24);
    checkOutput("bounce busy cleared", {28'b0, bus.BUSY}, 32'h0);
    checkOutput("bounce state", {28'b0, bus.STATE}, 32'h1);

    // Release channel 0.
    applyStimulus(24, 4'b0000);
    q.push_back('{at: 36, rise: 4'b0000, fall: 4'b0001, state: 4'b0000});
    goTo(28);
    checkOutput("release busy", {28'b0, bus.BUSY}, 32'h1);
    goTo(37);
    checkOutput("release state", {28'b0, bus.STATE}, 32'h0);

    // Two channels change together.
    applyStimulus(37, 4'hA);
    q.push_back('{at: 48, rise: 4'hA, fall: 4'h0, state: 4'hA});
    goTo(40);
    checkOutput("simul busy", {28'b0, bus.BUSY}, 32'hA);
    goTo(49);
    checkOutput("simul state", {28'b0, bus.STATE}, 32'hA);
    checkOutput("simul rise cleared", {28'b0, bus.RISE}, 32'h0);

    // Freeze for 20 clocks mid-pending: acceptance slides from 60 to 80.
    applyStimulus(49, 4'hB);
    q.push_back('{at: 80, rise: 4'b0001, fall: 4'b0000, state: 4'hB});
    goTo(52);
    checkOutput("freeze busy before", {28'b0, bus.BUSY}, 32'h1);
    goTo(53);
    bus.EN = 1'b0;
    goTo(73);
    checkOutput("frozen state", {28'b0, bus.STATE}, 32'hA);
    checkOutput("frozen busy",  {28'b0, bus.BUSY},  32'h1);
    bus.EN = 1'b1;
    goTo(76);
    checkOutput("resumed busy", {28'b0, bus.BUSY}, 32'h1);
    goTo(81);
    checkOutput("resumed state", {28'b0, bus.STATE}, 32'hB);
    checkOutput("resumed busy done", {28'b0, bus.BUSY}, 32'h0);

    // Reset while channel 2 is pending: change discarded, no pulse.
    applyStimulus(81, 4'hF);
    goTo(84);
    checkOutput("pending before reset", {28'b0, bus.BUSY}, 32'h4);
    goTo(85);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("mid reset busy",  {28'b0, bus.BUSY},  32'h0);
    checkOutput("mid reset state", {28'b0, bus.STATE}, 32'h0);
    checkOutput("mid reset rise",  {28'b0, bus.RISE},  32'h0);
    checkOutput("mid reset fall",  {28'b0, bus.FALL},  32'h0);
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    bus.SW = 4'h0;
    goTo(16);
    checkOutput("post reset state", {28'b0, bus.STATE}, 32'h0);
    checkOutput("post reset busy",  {28'b0, bus.BUSY},  32'h0);
    checkOutput("pulses outstanding", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
